// File: rtl/vga_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : vga_stream_tx
// Purpose  : Pixel-stream to VGA transmitter. RGB444 pixels from a
//            valid/ready producer are buffered in a small FIFO and emitted in
//            raster order with sync, display-enable and row/column strobes.
//            Frame alignment is enforced with the producer's start-of-frame
//            flag. Underrun and realignment events are reported as pulses.
// Ports    : clk, rst (async, active-high)
//            s_data[11:0], s_sof, s_valid -> s_ready     pixel stream in
//            r, g, b [3:0], hs, vs (active-low)          VGA pins
//            rdn (active-low enable), row_addr, col_addr capture strobes
//            underrun, resync                            one-clk event pulses
// Revision : 1.0  initial release
// ============================================================================
module vga_stream_tx #(
    parameter int PIX_DIV = 4,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] s_data,
    input  logic        s_sof,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        rdn,
    output logic [8:0]  row_addr,
    output logic [9:0]  col_addr,
    output logic        underrun,
    output logic        resync
);

    localparam int c_H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int c_V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int c_HA0   = H_SYNC + H_BP;
    localparam int c_VA0   = V_SYNC + V_BP;
    localparam int c_DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_PTR_ONE = 1;

    // ------------------------------------------------------------------
    // Pixel tick and raster counters
    // ------------------------------------------------------------------
    logic [c_DW-1:0] r_div;
    logic [9:0]      r_h_cnt;
    logic [9:0]      r_v_cnt;
    logic            w_tick;

    assign w_tick = (r_div == c_DW'(PIX_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + c_DW'(1);
            if (w_tick) begin
                if (r_h_cnt == 10'(c_H_TOT - 1)) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == 10'(c_V_TOT - 1)) ? '0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    logic w_h_sync, w_v_sync, w_h_act, w_v_act, w_active, w_first, w_frame_start;

    assign w_h_sync      = (r_h_cnt < 10'(H_SYNC));
    assign w_v_sync      = (r_v_cnt < 10'(V_SYNC));
    assign w_h_act       = (r_h_cnt >= 10'(c_HA0)) && (r_h_cnt < 10'(c_HA0 + H_ACT));
    assign w_v_act       = (r_v_cnt >= 10'(c_VA0)) && (r_v_cnt < 10'(c_VA0 + V_ACT));
    assign w_active      = w_h_act && w_v_act;
    assign w_first       = w_active && (r_h_cnt == 10'(c_HA0)) && (r_v_cnt == 10'(c_VA0));
    assign w_frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    // ------------------------------------------------------------------
    // Pixel FIFO: entries are {sof, data}; pointers carry a wrap bit
    // ------------------------------------------------------------------
    logic [12:0]      r_mem [c_DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             r_ready_en;
    logic             w_empty, w_full, w_push, w_pop;
    logic [12:0]      w_head;
    logic             w_head_sof;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                        (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    // A pop in the same cycle does not open a slot for the producer.
    assign s_ready    = r_ready_en && !w_full;
    assign w_push     = s_valid && s_ready;
    assign w_head     = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign w_head_sof = w_head[12];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {s_sof, s_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Pop / alignment decision
    // Discard mode drains stale non-sof words one per clk (independent of
    // the pixel tick) after a misaligned frame start. A sof word reached
    // anywhere other than pixel (0,0) is parked at the head until the next
    // frame start; the fault is reported once per frame.
    // ------------------------------------------------------------------
    logic r_discard, r_resync_done;
    logic w_show, w_set_under, w_set_resync, w_discard_nxt;

    always_comb begin
        w_pop         = 1'b0;
        w_show        = 1'b0;
        w_set_under   = 1'b0;
        w_set_resync  = 1'b0;
        w_discard_nxt = r_discard;
        if (w_tick && w_active) begin
            if (w_empty) begin
                w_set_under   = 1'b1;
                w_discard_nxt = 1'b0;
            end else if (w_first) begin
                w_pop = 1'b1;
                if (w_head_sof) begin
                    w_show        = 1'b1;
                    w_discard_nxt = 1'b0;
                end else begin
                    w_set_resync  = 1'b1;
                    w_discard_nxt = 1'b1;
                end
            end else if (w_head_sof) begin
                w_set_resync  = !r_resync_done;
                w_discard_nxt = 1'b0;
            end else if (r_discard) begin
                w_pop = 1'b1;
            end else begin
                w_pop  = 1'b1;
                w_show = 1'b1;
            end
        end else if (r_discard) begin
            if (w_empty || w_head_sof) w_discard_nxt = 1'b0;
            else                       w_pop         = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_discard     <= 1'b0;
            r_resync_done <= 1'b0;
        end else begin
            r_discard <= w_discard_nxt;
            if (w_tick && w_frame_start) r_resync_done <= 1'b0;
            else if (w_set_resync)       r_resync_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered pins: reflect the counter values held before the tick
    // ------------------------------------------------------------------
    logic [11:0] r_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs       <= 1'b1;
            vs       <= 1'b1;
            rdn      <= 1'b1;
            r_rgb    <= '0;
            row_addr <= '0;
            col_addr <= '0;
            underrun <= 1'b0;
            resync   <= 1'b0;
        end else begin
            underrun <= w_set_under;
            resync   <= w_set_resync;
            if (w_tick) begin
                hs       <= !w_h_sync;
                vs       <= !w_v_sync;
                rdn      <= !w_active;
                r_rgb    <= w_show ? w_head[11:0] : 12'd0;
                col_addr <= w_active ? (r_h_cnt - 10'(c_HA0)) : 10'd0;
                row_addr <= w_active ? 9'(r_v_cnt - 10'(c_VA0)) : 9'd0;
            end
        end
    end

    assign r = r_rgb[11:8];
    assign g = r_rgb[7:4];
    assign b = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_stream_tx
// Purpose  : Self-checking bench for vga_stream_tx on a reduced raster
//            (14 x 7 ticks, 8 x 4 active, 2 clk per tick, 8-deep FIFO).
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_stream_tx;

    localparam int PD  = 2;
    localparam int TPF = 98;   // ticks per frame: 14 * 7

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  r, g, b;
    logic        hs, vs, rdn, underrun, resync;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;

    vga_stream_tx #(
        .PIX_DIV(PD), .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .FIFO_AW(3)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
        .s_ready(s_ready), .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .rdn(rdn),
        .row_addr(row_addr), .col_addr(col_addr), .underrun(underrun), .resync(resync)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- producer: pixel (r,c) carries {r, c, 4'h5} ----------
    int p_en = 0, p_r = 0, p_c = 0, p_junk = 0;
    bit p_rdy;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                s_valid = 1'b0;
            end else begin
                s_valid = (p_en != 0);
                s_sof   = (p_junk == 0) && (p_r == 0) && (p_c == 0);
                s_data  = (p_junk > 0) ? 12'hBAD : {4'(p_r), 4'(p_c), 4'h5};
            end
            p_rdy = s_ready;
            @(posedge clk);
            if (s_valid && p_rdy && !rst) begin
                if (p_junk > 0) p_junk--;
                else begin
                    p_c++;
                    if (p_c == 8) begin
                        p_c = 0;
                        p_r = (p_r == 3) ? 0 : p_r + 1;
                    end
                end
            end
        end
    end

    // ---------------- tick stepping and per-frame statistics --------------
    int f_under, f_resync, f_act, f_bad, f_lit;

    task automatic clear_stats();
        f_under = 0; f_resync = 0; f_act = 0; f_bad = 0; f_lit = 0;
    endtask

    task automatic step();
        logic [11:0] exp_px;
        repeat (PD) @(posedge clk);
        #1;
        if (underrun) f_under++;
        if (resync)   f_resync++;
        if (!rdn) begin
            exp_px = {row_addr[3:0], col_addr[3:0], 4'h5};
            f_act++;
            if ({r, g, b} !== exp_px) f_bad++;
            if ({r, g, b} != 12'h000) f_lit++;
        end
    endtask

    task automatic run_frame(input int gap_start, input int gap_end);
        clear_stats();
        for (int t = 0; t < TPF; t++) begin
            step();
            if (t == gap_start) p_en = 0;
            if (t == gap_end)   p_en = 1;
        end
    endtask

    task automatic restart(input int junk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        p_en = 1; p_r = 0; p_c = 0; p_junk = junk;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_clean(input string tag);
        chk({tag, " underrun"}, 64'(f_under), 64'd0);
        chk({tag, " resync"},   64'(f_resync), 64'd0);
        chk({tag, " bad pixels"}, 64'(f_bad), 64'd0);
        chk({tag, " active ticks"}, 64'(f_act), 64'd32);
    endtask

    // ---------------- directed raster vectors ------------------------------
    typedef struct {
        int          k;
        logic        hs, vs, rdn;
        logic [8:0]  row;
        logic [9:0]  col;
        logic [11:0] rgb;
    } vec_t;

    localparam int NV = 14;
    vec_t vec [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int hs_lo, vs_lo, rdn_lo, un_hi, res_b;

        vec[0]  = '{0,   1'b0, 1'b0, 1'b1, 9'd0, 10'd0, 12'h000};
        vec[1]  = '{3,   1'b1, 1'b0, 1'b1, 9'd0, 10'd0, 12'h000};
        vec[2]  = '{14,  1'b0, 1'b1, 1'b1, 9'd0, 10'd0, 12'h000};
        vec[3]  = '{20,  1'b1, 1'b1, 1'b1, 9'd0, 10'd0, 12'h000};
        vec[4]  = '{32,  1'b1, 1'b1, 1'b0, 9'd0, 10'd0, 12'h005};
        vec[5]  = '{39,  1'b1, 1'b1, 1'b0, 9'd0, 10'd7, 12'h075};
        vec[6]  = '{40,  1'b1, 1'b1, 1'b1, 9'd0, 10'd0, 12'h000};
        vec[7]  = '{47,  1'b1, 1'b1, 1'b0, 9'd1, 10'd1, 12'h115};
        vec[8]  = '{64,  1'b1, 1'b1, 1'b0, 9'd2, 10'd4, 12'h245};
        vec[9]  = '{81,  1'b1, 1'b1, 1'b0, 9'd3, 10'd7, 12'h375};
        vec[10] = '{85,  1'b0, 1'b1, 1'b1, 9'd0, 10'd0, 12'h000};
        vec[11] = '{98,  1'b0, 1'b0, 1'b1, 9'd0, 10'd0, 12'h000};
        vec[12] = '{130, 1'b1, 1'b1, 1'b0, 9'd0, 10'd0, 12'h005};
        vec[13] = '{179, 1'b1, 1'b1, 1'b0, 9'd3, 10'd7, 12'h375};

        // ---- reset values, s_ready after release ----
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {hs, vs, rdn, r, g, b, row_addr, col_addr, underrun, resync, s_ready},
            {3'b111, 12'd0, 9'd0, 10'd0, 3'b000});
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready after release", {s_ready, hs, vs, rdn}, 4'b1111);
        @(posedge clk); #1;
        chk("first tick sync", {hs, vs, rdn}, 3'b001);

        // ---- idle producer: one full frame window of per-clk counts ----
        repeat (20) @(posedge clk);
        hs_lo = 0; vs_lo = 0; rdn_lo = 0; un_hi = 0;
        for (int i = 0; i < 2 * TPF; i++) begin
            @(posedge clk); #1;
            if (!hs)     hs_lo++;
            if (!vs)     vs_lo++;
            if (!rdn)    rdn_lo++;
            if (underrun) un_hi++;
        end
        chk("idle hs low clks",  64'(hs_lo),  64'd28);
        chk("idle vs low clks",  64'(vs_lo),  64'd28);
        chk("idle rdn low clks", 64'(rdn_lo), 64'd64);
        chk("idle underrun clks", 64'(un_hi), 64'd32);

        // ---- aligned stream, two frames, table of raster points ----
        restart(0);
        clear_stats();
        idx = 0;
        for (int kk = 0; kk < 2 * TPF; kk++) begin
            step();
            if (idx < NV && vec[idx].k == kk) begin
                chk($sformatf("raster tick %0d", kk),
                    {hs, vs, rdn, row_addr, col_addr, r, g, b},
                    {vec[idx].hs, vec[idx].vs, vec[idx].rdn, vec[idx].row, vec[idx].col, vec[idx].rgb});
                idx++;
            end
        end
        chk("stream underrun", 64'(f_under), 64'd0);
        chk("stream resync", 64'(f_resync), 64'd0);
        chk("stream bad pixels", 64'(f_bad), 64'd0);
        chk("stream active ticks", 64'(f_act), 64'd64);

        // ---- producer gap mid-frame, realignment on a later frame ----
        run_frame(47, 87);
        chk("gap underrun seen", 64'(f_under > 0), 64'd1);
        res_b = f_resync;
        run_frame(-1, -1);
        chk("gap single resync", 64'(res_b + f_resync), 64'd1);
        run_frame(-1, -1);
        chk_clean("gap recovered");

        // ---- five stale words ahead of a sof frame ----
        restart(5);
        run_frame(-1, -1);
        chk("junk resync", 64'(f_resync), 64'd1);
        chk("junk underrun", 64'(f_under), 64'd0);
        chk("junk frame black", 64'(f_lit), 64'd0);
        run_frame(-1, -1);
        chk_clean("junk recovered");

        // ---- reset mid-frame at row 2 ----
        for (int t = 0; t < 64; t++) step();
        chk("pre-reset active", {31'd0, rdn}, 64'd0);
        rst = 1'b1;
        #1;
        chk("async reset outputs", {hs, vs, rdn, r, g, b, row_addr, col_addr, underrun, resync, s_ready},
            {3'b111, 12'd0, 9'd0, 10'd0, 3'b000});
        p_r = 0; p_c = 0; p_junk = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("vs before first tick", {31'd0, vs}, 64'd1);
        @(posedge clk); #1;
        chk("vs falls at first tick", {31'd0, vs}, 64'd0);
        repeat (27) @(posedge clk);
        #1;
        chk("vs still low end of line", {31'd0, vs}, 64'd0);
        @(posedge clk); #1;
        chk("vs rises after one line", {31'd0, vs}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
